alu_exec: RTL and testbench
===========================

ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the data path width in bits.
REQ-002 The block SHALL have clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have rst_i, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have valid_i, input, 1 bit: an operation request is present.
REQ-005 The block SHALL have ready_o, output, 1 bit: the block can accept a request.
REQ-006 The block SHALL have ALUCtrl_i, input, 4 bits: operation code from the ALU control decoder.
REQ-007 The block SHALL have data1_i and data2_i, inputs, WIDTH bits each: operands.
REQ-008 The block SHALL have valid_o, output, 1 bit: data_o and zero_o hold a result.
REQ-009 The block SHALL have ready_i, input, 1 bit: the consumer takes the result.
REQ-010 The block SHALL have data_o, output, WIDTH bits: the registered result.
REQ-011 The block SHALL have zero_o, output, 1 bit: high when data_o equals 0.

Function
REQ-012 A request SHALL be accepted on an edge where valid_i and ready_o are both high; operands and code are captured at that edge.
REQ-013 ALUCtrl_i codes SHALL map to operations as follows:
- 0000 AND
- 0001 XOR
- 0010 SLL by data2_i[4:0]
- 0011 ADD
- 0100 SUB
- 0101 MUL, low WIDTH bits of the product
- 0110, 1000, 1001 ADD (addi, load address, store address)
- 0111 SRA by data2_i[4:0]
- 1010 SUB (branch compare)
- 1011-1111: data_o = 0 and zero_o = 1
REQ-014 The state machine SHALL have three states:
- IDLE: ready_o = 1, valid_o = 0
- MUL: ready_o = 0, valid_o = 0
- DONE: ready_o = 0, valid_o = 1
REQ-015 On accept in IDLE, a non-MUL code SHALL go to DONE with the result registered, so valid_o rises exactly 1 cycle after accept.
REQ-016 On accept in IDLE, MUL SHALL go to MUL state and run a radix-2 shift-add multiply, one multiplier bit per cycle, with a 6-bit iteration counter starting at 0.
REQ-017 MUL state SHALL go to DONE after the counter reaches WIDTH-1, so valid_o rises exactly WIDTH+1 cycles after accept.
REQ-018 In DONE, data_o and zero_o SHALL hold stable until ready_i is high; on that edge the state SHALL return to IDLE.
REQ-019 The block SHALL NOT accept a request while in DONE, so throughput is at most one operation per 2 cycles.
REQ-020 Arithmetic SHALL wrap modulo 2^WIDTH, with no overflow flag.
REQ-021 A shift amount of 0 SHALL return data1_i unchanged.
REQ-022 Operand changes after accept SHALL NOT affect the result.

Reset
REQ-023 While rst_i is low, the state SHALL be IDLE and the outputs SHALL be: ready_o = 1, valid_o = 0, data_o = 0, zero_o = 1. The iteration counter and the accumulator SHALL be 0.
REQ-024 Reset asserted during MUL or DONE SHALL abort the operation, and no valid_o SHALL be produced for it.

Configuration
REQ-025 When ALU_EXEC_FAST_MUL_EN is defined, MUL SHALL be computed in a single cycle like the other operations: latency 1, MUL state unused, no iteration logic.
REQ-026 When ALU_EXEC_FAST_MUL_EN is undefined, MUL SHALL use the iterative path of REQ-016 and REQ-017; the results SHALL be identical in both builds.

Structure
REQ-027 Package alu_exec_pkg SHALL hold:
- the 4-bit ALUCtrl code constants, shared with the ALU control decoder
- the state encoding type (IDLE/MUL/DONE)
REQ-028 The iterative multiplier SHALL be the sub-module alu_mul_iter, with start/done handshake, operands, and the WIDTH-bit product; it is excluded when ALU_EXEC_FAST_MUL_EN is defined.

Verification
REQ-029 The bench SHALL cover: ADD of 0x00000005 and 0xFFFFFFFB -> valid_o 1 cycle later, data_o = 0, zero_o = 1.
REQ-030 The bench SHALL cover: SRA of 0x80000000 by data2_i = 0x00000021 (shamt 1) -> data_o = 0xC0000000.
REQ-031 The bench SHALL cover: MUL of 0x00010001 and 0x00010001 in the iterative build -> valid_o 33 cycles after accept, data_o = 0x00020001. The fast build -> same data_o after 1 cycle.
REQ-032 The bench SHALL cover: SUB result held with ready_i = 0 for 5 cycles -> valid_o and data_o stable, ready_o = 0, then IDLE 1 cycle after ready_i = 1.
REQ-033 The bench SHALL cover: rst_i pulsed low at cycle 10 of a MUL -> outputs immediately at reset values, no valid_o. A following AND of 0xF0F0F0F0 and 0xFF00FF00 -> data_o = 0xF000F000.
REQ-034 The bench SHALL cover: code 1100 -> data_o = 0, zero_o = 1, valid_o after 1 cycle.

Source files
------------

// File: rtl/alu_exec_pkg.sv
// Shared ALU control codes and execute-stage state encoding.
package alu_exec_pkg;

   localparam int unsigned ALU_CTRL_W = 4;
   localparam int unsigned MUL_CNT_W  = 6;

   localparam logic [ALU_CTRL_W-1:0] ALU_AND    = 4'b0000;
   localparam logic [ALU_CTRL_W-1:0] ALU_XOR    = 4'b0001;
   localparam logic [ALU_CTRL_W-1:0] ALU_SLL    = 4'b0010;
   localparam logic [ALU_CTRL_W-1:0] ALU_ADD    = 4'b0011;
   localparam logic [ALU_CTRL_W-1:0] ALU_SUB    = 4'b0100;
   localparam logic [ALU_CTRL_W-1:0] ALU_MUL    = 4'b0101;
   localparam logic [ALU_CTRL_W-1:0] ALU_ADDI   = 4'b0110;
   localparam logic [ALU_CTRL_W-1:0] ALU_SRA    = 4'b0111;
   localparam logic [ALU_CTRL_W-1:0] ALU_LDADDR = 4'b1000;
   localparam logic [ALU_CTRL_W-1:0] ALU_STADDR = 4'b1001;
   localparam logic [ALU_CTRL_W-1:0] ALU_BRCMP  = 4'b1010;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Radix-2 shift-add multiplier: one multiplier bit per cycle, low WIDTH bits of product.
// Not built when ALU_EXEC_FAST_MUL_EN is defined.
`ifndef ALU_EXEC_FAST_MUL_EN
module alu_mul_iter
   import alu_exec_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done_c,
   output logic [WIDTH-1:0] product_c
);

   logic                 busy_q;
   logic [MUL_CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0]     acc_q;
   logic [WIDTH-1:0]     mcand_q;
   logic [WIDTH-1:0]     mplier_q;

   // Final add is visible combinationally so the caller can register it on the last step.
   assign product_c = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign done_c    = busy_q && (cnt_q == MUL_CNT_W'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q   <= 1'b0;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
      end else if (start) begin
         busy_q   <= 1'b1;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= a;
         mplier_q <= b;
      end else if (busy_q) begin
         acc_q    <= product_c;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q + MUL_CNT_W'(1);
         if (done_c) begin
            busy_q <= 1'b0;
         end
      end
   end

endmodule
`endif

// File: rtl/alu_exec.sv
// Execute-stage ALU with valid/ready handshake and registered result.
// Define ALU_EXEC_FAST_MUL_EN for single-cycle MUL instead of the iterative multiplier.
module alu_exec
   import alu_exec_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic [ALU_CTRL_W-1:0] ALUCtrl_i,
   input  logic [WIDTH-1:0]      data1_i,
   input  logic [WIDTH-1:0]      data2_i,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic [WIDTH-1:0]      data_o,
   output logic                  zero_o
);

   alu_state_e       state_q;
   alu_state_e       state_nxt;
   logic             accept_c;
   logic             load_c;
   logic             mul_start_c;
   logic [WIDTH-1:0] alu_c;
   logic [WIDTH-1:0] res_c;

   assign accept_c = valid_i && ready_o;

   // Single-cycle operations; MUL appears here only in the fast build.
   always_comb begin
      alu_c = '0;
      case (ALUCtrl_i)
         ALU_AND:    alu_c = data1_i & data2_i;
         ALU_XOR:    alu_c = data1_i ^ data2_i;
         ALU_SLL:    alu_c = data1_i << data2_i[4:0];
         ALU_SRA:    alu_c = WIDTH'($signed(data1_i) >>> data2_i[4:0]);
         ALU_ADD, ALU_ADDI, ALU_LDADDR, ALU_STADDR:
                     alu_c = data1_i + data2_i;
         ALU_SUB, ALU_BRCMP:
                     alu_c = data1_i - data2_i;
`ifdef ALU_EXEC_FAST_MUL_EN
         ALU_MUL:    alu_c = WIDTH'(data1_i * data2_i);
`endif
         default:    alu_c = '0;
      endcase
   end

`ifndef ALU_EXEC_FAST_MUL_EN
   logic             mul_done_c;
   logic [WIDTH-1:0] mul_product_c;

   alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk       (clk_i),
      .rst_n     (rst_i),
      .start     (mul_start_c),
      .a         (data1_i),
      .b         (data2_i),
      .done_c    (mul_done_c),
      .product_c (mul_product_c)
   );
`endif

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state_q <= IDLE;
      else        state_q <= state_nxt;
   end

   always_comb begin
      state_nxt   = state_q;
      load_c      = 1'b0;
      mul_start_c = 1'b0;
      res_c       = alu_c;
      case (state_q)
         IDLE: begin
            if (accept_c) begin
`ifndef ALU_EXEC_FAST_MUL_EN
               if (ALUCtrl_i == ALU_MUL) begin
                  mul_start_c = 1'b1;
                  state_nxt   = MUL;
               end else
`endif
               begin
                  load_c    = 1'b1;
                  state_nxt = DONE;
               end
            end
         end
         MUL: begin
`ifndef ALU_EXEC_FAST_MUL_EN
            res_c = mul_product_c;
            if (mul_done_c) begin
               load_c    = 1'b1;
               state_nxt = DONE;
            end
`else
            state_nxt = IDLE;
`endif
         end
         DONE: begin
            if (ready_i) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake flags are registered decodes of the next state.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ready_o <= 1'b1;
         valid_o <= 1'b0;
         data_o  <= '0;
         zero_o  <= 1'b1;
      end else begin
         ready_o <= (state_nxt == IDLE);
         valid_o <= (state_nxt == DONE);
         if (load_c) begin
            data_o <= res_c;
            zero_o <= (res_c == '0);
         end
      end
   end

endmodule

// File: tb/tb_alu_exec.sv
// Bench for alu_exec: cycle-level latency model plus directed vectors with literal expectations.
module tb_alu_exec;

   localparam int unsigned WIDTH = 32;
`ifdef ALU_EXEC_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = WIDTH + 1;
`endif

   logic             clk_i = 1'b0;
   logic             rst_i = 1'b0;
   logic             valid_i = 1'b0;
   logic             ready_o;
   logic [3:0]       ALUCtrl_i = 4'd0;
   logic [WIDTH-1:0] data1_i = '0;
   logic [WIDTH-1:0] data2_i = '0;
   logic             valid_o;
   logic             ready_i = 1'b0;
   logic [WIDTH-1:0] data_o;
   logic             zero_o;

   int checks = 0;
   int errors = 0;

   alu_exec #(.WIDTH(WIDTH)) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .valid_i   (valid_i),
      .ready_o   (ready_o),
      .ALUCtrl_i (ALUCtrl_i),
      .data1_i   (data1_i),
      .data2_i   (data2_i),
      .valid_o   (valid_o),
      .ready_i   (ready_i),
      .data_o    (data_o),
      .zero_o    (zero_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference operation straight from the opcode table.
   function automatic logic [31:0] ref_op(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
      logic [63:0] ext;
      logic [63:0] prod;
      int          sh;
      sh = int'(b[4:0]);
      case (c)
         4'd0:                 return a & b;
         4'd1:                 return a ^ b;
         4'd2:                 return a << sh;
         4'd3, 4'd6, 4'd8, 4'd9: return a + b;
         4'd4, 4'd10:          return a - b;
         4'd5: begin
            prod = {32'd0, a} * {32'd0, b};
            return prod[31:0];
         end
         4'd7: begin
            ext = {{32{a[31]}}, a} >> sh;
            return ext[31:0];
         end
         default:              return 32'd0;
      endcase
   endfunction

   // Model: a request waits its latency, then the result is offered until taken.
   logic        m_ready, m_valid, m_zero;
   logic [31:0] m_data, m_res;
   int          m_wait;

   always @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         m_ready = 1'b1; m_valid = 1'b0; m_data = 32'd0; m_zero = 1'b1; m_wait = 0;
      end else if (m_valid) begin
         if (ready_i) begin
            m_valid = 1'b0; m_ready = 1'b1;
         end
      end else if (!m_ready) begin
         m_wait--;
         if (m_wait == 0) begin
            m_valid = 1'b1; m_data = m_res; m_zero = (m_res == 32'd0);
         end
      end else if (valid_i) begin
         m_res   = ref_op(ALUCtrl_i, data1_i, data2_i);
         m_wait  = (ALUCtrl_i == 4'd5) ? MUL_LAT - 1 : 0;
         m_ready = 1'b0;
         if (m_wait == 0) begin
            m_valid = 1'b1; m_data = m_res; m_zero = (m_res == 32'd0);
         end
      end
   end

   always @(negedge clk_i) begin
      if (rst_i) begin
         chk("model_ready", 64'(ready_o), 64'(m_ready));
         chk("model_valid", 64'(valid_o), 64'(m_valid));
         chk("model_data",  64'(data_o),  64'(m_data));
         chk("model_zero",  64'(zero_o),  64'(m_zero));
      end
   end

   // Present one request; operands are scrambled right after the accept edge.
   task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk_i);
      ALUCtrl_i = c; data1_i = a; data2_i = b; valid_i = 1'b1;
      @(posedge clk_i);
      #1;
      valid_i = 1'b0; ALUCtrl_i = 4'($urandom); data1_i = $urandom; data2_i = $urandom;
   endtask

   // Latency counted from the accept edge (1 = valid right after accept).
   task automatic wait_valid(output int lat);
      lat = 1;
      while (!valid_o && lat < 200) begin
         @(posedge clk_i);
         #1;
         lat++;
      end
      if (lat >= 200) chk("valid_timeout", 64'(valid_o), 64'd1);
   endtask

   task automatic consume();
      ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      ready_i = 1'b0;
      chk("consume_ready", 64'(ready_o), 64'd1);
      chk("consume_valid", 64'(valid_o), 64'd0);
   endtask

   task automatic run_op(input string name, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
      int lat;
      issue(c, a, b);
      wait_valid(lat);
      chk({name, "_lat"},  64'(lat),    64'(exp_lat));
      chk({name, "_data"}, 64'(data_o), 64'(exp));
      chk({name, "_zero"}, 64'(zero_o), 64'(exp == 32'd0));
      consume();
   endtask

   typedef struct {
      logic [3:0]  c;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[10] = '{
      '{4'b0001, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00},
      '{4'b0010, 32'h00000001, 32'hFFFFFFE4, 32'h00000010},
      '{4'b0010, 32'h12345678, 32'h00000020, 32'h12345678},
      '{4'b0111, 32'h7FFF0000, 32'h00000008, 32'h007FFF00},
      '{4'b0111, 32'h87654321, 32'h00000000, 32'h87654321},
      '{4'b0110, 32'hFFFFFFFF, 32'h00000001, 32'h00000000},
      '{4'b1000, 32'h00000100, 32'h00000020, 32'h00000120},
      '{4'b1001, 32'h7FFFFFFF, 32'h00000001, 32'h80000000},
      '{4'b1010, 32'h00000000, 32'h00000001, 32'hFFFFFFFF},
      '{4'b1111, 32'h00001234, 32'h00005678, 32'h00000000}
   };

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, errors %0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      @(negedge clk_i);
      chk("rst_ready", 64'(ready_o), 64'd1);
      chk("rst_valid", 64'(valid_o), 64'd0);
      chk("rst_data",  64'(data_o),  64'd0);
      chk("rst_zero",  64'(zero_o),  64'd1);
      repeat (2) @(negedge clk_i);
      rst_i = 1'b1;

      run_op("add_zero", 4'b0011, 32'h00000005, 32'hFFFFFFFB, 32'h00000000, 1);
      run_op("sra_neg",  4'b0111, 32'h80000000, 32'h00000021, 32'hC0000000, 1);
      run_op("mul_iter", 4'b0101, 32'h00010001, 32'h00010001, 32'h00020001, MUL_LAT);
      run_op("mul_wrap", 4'b0101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, MUL_LAT);

      // Result held under back-pressure while a new request is waiting.
      issue(4'b0100, 32'h0000000A, 32'h00000003);
      wait_valid(lat);
      chk("sub_lat", 64'(lat), 64'd1);
      ALUCtrl_i = 4'b0011; data1_i = 32'h11111111; data2_i = 32'h22222222; valid_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk_i);
         #1;
         chk("hold_valid", 64'(valid_o), 64'd1);
         chk("hold_data",  64'(data_o),  64'h7);
         chk("hold_ready", 64'(ready_o), 64'd0);
      end
      ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      ready_i = 1'b0;
      valid_i = 1'b0;
      chk("release_ready", 64'(ready_o), 64'd1);
      chk("release_valid", 64'(valid_o), 64'd0);
      @(posedge clk_i);
      #1;
      chk("no_accept_in_done", 64'(ready_o), 64'd1);

      // Reset in the middle of a multiply.
      issue(4'b0101, 32'h00010001, 32'h00010001);
      repeat (9) @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
      #1;
      chk("abort_ready", 64'(ready_o), 64'd1);
      chk("abort_valid", 64'(valid_o), 64'd0);
      chk("abort_data",  64'(data_o),  64'd0);
      chk("abort_zero",  64'(zero_o),  64'd1);
      repeat (2) @(negedge clk_i);
      rst_i = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk_i);
         #1;
         chk("abort_no_valid", 64'(valid_o), 64'd0);
      end
      run_op("and_after", 4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1);
      run_op("code_1100", 4'b1100, 32'hDEADBEEF, 32'h12345678, 32'h00000000, 1);

      foreach (vecs[i]) begin
         run_op($sformatf("vec%0d", i), vecs[i].c, vecs[i].a, vecs[i].b, vecs[i].exp, 1);
      end

      repeat (3) @(posedge clk_i);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
